sha1_padder: RTL

SHA1_PADDER -- requirements
Module: sha1_padder

---
 rtl/sha1_padder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha1_padder (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last,
    output logic         busy
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_EMIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [5:0]    r_ptr, w_ptr_nxt;
    logic [60:0]   r_cnt, w_cnt_nxt;
    logic          r_pad_started, w_pad_started_nxt;
    logic          r_msg_done, w_msg_done_nxt;
    logic          r_last, w_last_nxt;
    logic [511:0]  r_buf;

    logic          w_wr_en;
    logic [7:0]    w_wr_byte;
    logic          w_len_wr;
    logic [8:0]    w_bit_base;
    logic [63:0]   w_len;

    // Byte p sits in word p/4, most significant byte first.
    assign w_bit_base = {r_ptr[5:2], ~r_ptr[1:0], 3'b000};
    assign w_len      = {r_cnt, 3'b000};

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_cnt_nxt         = r_cnt;
        w_pad_started_nxt = r_pad_started;
        w_msg_done_nxt    = r_msg_done;
        w_last_nxt        = r_last;
        w_wr_en           = 1'b0;
        w_wr_byte         = in_data;
        w_len_wr          = 1'b0;
        case (r_state)
            S_FILL: begin
                if (in_valid) begin
                    w_wr_en   = 1'b1;
                    w_ptr_nxt = r_ptr + 6'd1;
                    w_cnt_nxt = r_cnt + 61'd1;
                    if (in_last) begin
                        w_msg_done_nxt    = 1'b1;
                        w_pad_started_nxt = 1'b0;
                    end
                    if (r_ptr == 6'd63) begin
                        w_state_nxt = S_EMIT;
                        w_last_nxt  = 1'b0;
                    end else if (in_last) begin
                        w_state_nxt = S_PAD;
                    end
                end
            end
            S_PAD: begin
                w_wr_en           = 1'b1;
                w_wr_byte         = r_pad_started ? 8'h00 : 8'h80;
                w_pad_started_nxt = 1'b1;
                w_ptr_nxt         = r_ptr + 6'd1;
                if (r_ptr == 6'd55) begin
                    w_state_nxt = S_LEN;
                end else if (r_ptr == 6'd63) begin
                    w_state_nxt = S_EMIT;
                    w_last_nxt  = 1'b0;
                end
            end
            S_LEN: begin
                w_len_wr    = 1'b1;
                w_ptr_nxt   = 6'd0;
                w_state_nxt = S_EMIT;
                w_last_nxt  = 1'b1;
            end
            S_EMIT: begin
                if (blk_ready) begin
                    w_last_nxt = 1'b0;
                    if (r_last) begin
                        w_state_nxt       = S_FILL;
                        w_cnt_nxt         = '0;
                        w_ptr_nxt         = '0;
                        w_pad_started_nxt = 1'b0;
                        w_msg_done_nxt    = 1'b0;
                    end else begin
                        // A message that already ended keeps padding into the next block.
                        w_state_nxt = r_msg_done ? S_PAD : S_FILL;
                    end
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_FILL;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_pad_started <= 1'b0;
            r_msg_done    <= 1'b0;
            r_last        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pad_started <= w_pad_started_nxt;
            r_msg_done    <= w_msg_done_nxt;
            r_last        <= w_last_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf <= '0;
        end else begin
            if (w_wr_en)
                r_buf[w_bit_base +: 8] <= w_wr_byte;
            // Word 14 takes the upper length half, word 15 the lower.
            if (w_len_wr)
                r_buf[511:448] <= {w_len[31:0], w_len[63:32]};
        end
    end

    assign in_ready  = (r_state == S_FILL) && !reset;
    assign blk_valid = (r_state == S_EMIT);
    assign blk_data  = r_buf;
    assign blk_last  = r_last;
    assign busy      = !((r_state == S_FILL) && (r_ptr == 6'd0) && (r_cnt == 61'd0));

endmodule
